// File: rtl/sipo_byte_assembler_if.sv
// rtl/sipo_byte_assembler_if.sv - completed-word valid/ready channel of the SIPO assembler
interface sipo_byte_assembler_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_ready;

  modport master (
    output o_data,
    output o_valid,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    output i_ready
  );
endinterface

// File: rtl/sipo_byte_assembler.sv
// rtl/sipo_byte_assembler.sv - serial-in parallel-out word assembler with one-word holding buffer
// Shifts one bit per enabled edge, hands completed words to a valid/ready consumer, flags drops.
module sipo_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_serial_bit,
  input  logic                       i_shift_en,
  sipo_byte_assembler_if.master      out_if,
  output logic                       o_overrun,
  output logic [$clog2(WIDTH)-1:0]   o_bit_count
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    count_q;
  logic             valid_q;
  logic             overrun_q;

  logic shift;
  logic complete;
  logic consume;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_next = {sr_q[WIDTH-2:0], i_serial_bit};
    end else begin : g_lsb_first
      assign sr_next = {i_serial_bit, sr_q[WIDTH-1:1]};
    end
  endgenerate

  // Clear outranks shifting, so a clear edge can never complete a word.
  always_comb begin
    shift    = i_shift_en && !i_clear;
    complete = shift && (count_q == LAST_BIT);
    consume  = valid_q && out_if.i_ready;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sr_q      <= '0;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (i_clear) begin
        sr_q      <= '0;
        count_q   <= '0;
        overrun_q <= 1'b0;
      end else if (shift) begin
        sr_q    <= sr_next;
        count_q <= complete ? '0 : count_q + CW'(1);
      end

      // Holding register: reload on completion only if it is empty or being drained this edge.
      if (complete && (!valid_q || consume)) begin
        data_q  <= sr_next;
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end

      if (complete && valid_q && !out_if.i_ready) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_if.o_data  = data_q;
  assign out_if.o_valid = valid_q;
  assign o_overrun      = overrun_q;
  assign o_bit_count    = count_q;
endmodule

// File: tb/tb_sipo_byte_assembler.sv
// tb/tb_sipo_byte_assembler.sv - directed vector bench for sipo_byte_assembler (MSB- and LSB-first instances)
module tb_sipo_byte_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic serial_bit = 1'b0;
  logic shift_en = 1'b0;
  logic ready = 1'b0;

  logic       ovr1, ovr0;
  logic [2:0] cnt1, cnt0;

  int tests = 0;
  int fails = 0;

  sipo_byte_assembler_if #(.WIDTH(8)) if1 ();
  sipo_byte_assembler_if #(.WIDTH(8)) if0 ();
  assign if1.i_ready = ready;
  assign if0.i_ready = ready;

  sipo_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk(clk), .i_rst(rst_n), .i_clear(clear), .i_serial_bit(serial_bit),
    .i_shift_en(shift_en), .out_if(if1), .o_overrun(ovr1), .o_bit_count(cnt1)
  );

  sipo_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_rst(rst_n), .i_clear(clear), .i_serial_bit(serial_bit),
    .i_shift_en(shift_en), .out_if(if0), .o_overrun(ovr0), .o_bit_count(cnt0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       bit_in;
    logic       en;
    logic       clr;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_d1;
    logic [7:0] exp_d0;
    logic [2:0] exp_cnt;
    logic       exp_ovr;
    logic       chk_data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic b, logic en, logic clr, logic rdy, logic ev,
                              logic [7:0] d1, logic [7:0] d0, logic [2:0] c,
                              logic ov, logic cd);
    vec_t v;
    v.bit_in = b; v.en = en; v.clr = clr; v.rdy = rdy; v.exp_valid = ev;
    v.exp_d1 = d1; v.exp_d0 = d0; v.exp_cnt = c; v.exp_ovr = ov; v.chk_data = cd;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(logic b, logic en, logic clr, logic rdy);
    serial_bit = b;
    shift_en   = en;
    clear      = clr;
    ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check_both(string name, logic ev, logic [7:0] d1, logic [7:0] d0,
                            logic [2:0] c, logic ov, logic cd);
    check({name, " valid msb"}, if1.o_valid, ev);
    check({name, " valid lsb"}, if0.o_valid, ev);
    check({name, " count msb"}, cnt1, c);
    check({name, " count lsb"}, cnt0, c);
    check({name, " overrun msb"}, ovr1, ov);
    check({name, " overrun lsb"}, ovr0, ov);
    if (cd) begin
      check({name, " data msb"}, if1.o_data, d1);
      check({name, " data lsb"}, if0.o_data, d0);
    end
  endtask

  logic [7:0] word_a = 8'hCA;
  logic [7:0] word_b = 8'h3C;
  logic [7:0] cap1[$];
  logic [7:0] cap0[$];
  int         hi1, hi0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic word with ready held high, then the valid pulse must drop after one cycle.
    for (int i = 0; i < 8; i++)
      add(word_a[7-i], 1'b1, 1'b0, 1'b1, i == 7, 8'hCA, 8'h53, 3'((i + 1) % 8), 1'b0, i == 7);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hCA, 8'h53, 3'd0, 1'b0, 1'b1);
    // Stalled consumer: second word dropped, overrun raised, then drain and clear.
    for (int i = 0; i < 8; i++)
      add(word_a[7-i], 1'b1, 1'b0, 1'b0, i == 7, 8'hCA, 8'h53, 3'((i + 1) % 8), 1'b0, i == 7);
    for (int i = 0; i < 8; i++)
      add(word_b[7-i], 1'b1, 1'b0, 1'b0, 1'b1, 8'hCA, 8'h53, 3'((i + 1) % 8), i == 7, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hCA, 8'h53, 3'd0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hCA, 8'h53, 3'd0, 1'b0, 1'b1);

    #2;
    check_both("reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].bit_in, vecs[i].en, vecs[i].clr, vecs[i].rdy);
      check_both($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_d1, vecs[i].exp_d0,
                 vecs[i].exp_cnt, vecs[i].exp_ovr, vecs[i].chk_data);
    end

    // Gapped shifting, ready held: two separate one-cycle pulses, no overrun.
    hi1 = 0;
    hi0 = 0;
    for (int k = 0; k < 32; k++) begin
      logic [7:0] w;
      w = (k < 16) ? word_a : word_b;
      step(w[7 - ((k % 16) / 2)], (k % 2) == 0, 1'b0, 1'b1);
      if (if1.o_valid) begin hi1++; cap1.push_back(if1.o_data); end
      if (if0.o_valid) begin hi0++; cap0.push_back(if0.o_data); end
    end
    check("gap valid cycles msb", hi1, 2);
    check("gap valid cycles lsb", hi0, 2);
    check("gap word0 msb", (cap1.size() > 0) ? cap1[0] : 8'hxx, 8'hCA);
    check("gap word1 msb", (cap1.size() > 1) ? cap1[1] : 8'hxx, 8'h3C);
    check("gap word0 lsb", (cap0.size() > 0) ? cap0[0] : 8'hxx, 8'h53);
    check("gap word1 lsb", (cap0.size() > 1) ? cap0[1] : 8'hxx, 8'h3C);
    check("gap overrun msb", ovr1, 1'b0);
    check("gap overrun lsb", ovr0, 1'b0);

    // Asynchronous reset mid-word must clear outputs before the next edge.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("pre-reset count", cnt1, 3'd5);
    check("pre-reset data", if1.o_data, 8'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    check_both("async reset", 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check_both("after reset ones", 1'b1, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ones consumed", if1.o_valid, 1'b0);

    // Clear wins over a simultaneous shift, then a full word assembles cleanly.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("partial count", cnt1, 3'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_both("clear vs shift", 1'b0, 8'hFF, 8'hFF, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(word_a[7-i], 1'b1, 1'b0, 1'b1);
    check_both("post-clear word", 1'b1, 8'hCA, 8'h53, 3'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
